// File: rtl/instr_sequencer.sv
// Program store and fetch sequencer: holds a small instruction RAM and issues one word at a
// time to the control FSM, advancing on its done pulse, with a watchdog on stalled execution.
module instr_sequencer #(
    parameter int OP_SIZE  = 4,
    parameter int ARG_SIZE = 3,
    parameter int ARG_NUM  = 2,
    parameter int ADDR_W   = 4,
    parameter int TIMEOUT  = 15,
    localparam int INSTR_W = OP_SIZE + ARG_NUM * ARG_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               run,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               done,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted,
    output logic               error
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int ARG_W = ARG_NUM * ARG_SIZE;

    localparam logic [OP_SIZE-1:0] OP_LOAD = OP_SIZE'(0);
    localparam logic [OP_SIZE-1:0] OP_MOVE = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] OP_XOR  = OP_SIZE'(3);
    localparam logic [OP_SIZE-1:0] OP_NOP  = OP_SIZE'(14);
    localparam logic [OP_SIZE-1:0] OP_HALT = OP_SIZE'(15);
    localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, {ARG_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc_n, last, last_n;
    logic [INSTR_W-1:0]  instr_n;
    logic [TW-1:0]       timer, timer_n;
    logic                error_n;
    logic                adv;

    logic [INSTR_W-1:0]  mem [DEPTH];
    logic [INSTR_W-1:0]  rd_word;
    logic [OP_SIZE-1:0]  rd_op;
    logic [ADDR_W:0]     len_m1;

    assign busy   = (state == S_FETCH) || (state == S_EXEC);
    assign halted = (state == S_HALT);

    // RAM is not reset; writes are only accepted while the sequencer is parked
    always_ff @(posedge clk) begin
        if (load_en && !busy)
            mem[load_addr] <= load_data;
    end

    assign rd_word = mem[pc];
    assign rd_op   = rd_word[INSTR_W-1 -: OP_SIZE];
    assign len_m1  = prog_len - (ADDR_W + 1)'(1);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instruction;
        timer_n = timer;
        error_n = error;
        last_n  = last;
        adv     = 1'b0;

        case (state)
            S_IDLE, S_HALT: begin
                instr_n = NOP_WORD;
                if (run) begin
                    pc_n    = '0;
                    error_n = 1'b0;
                    timer_n = '0;
                    // lengths beyond the RAM depth stop at the last address
                    last_n  = (prog_len > (ADDR_W + 1)'(DEPTH)) ? ADDR_W'(DEPTH - 1)
                                                                 : len_m1[ADDR_W-1:0];
                    state_n = (prog_len == '0) ? S_HALT : S_FETCH;
                end
            end
            S_FETCH: begin
                case (rd_op)
                    OP_LOAD, OP_MOVE, OP_ADD, OP_XOR: begin
                        instr_n = rd_word;
                        timer_n = '0;
                        state_n = S_EXEC;
                    end
                    OP_NOP:  adv = 1'b1;
                    OP_HALT: state_n = S_HALT;
                    default: begin
                        error_n = 1'b1;
                        state_n = S_HALT;
                    end
                endcase
            end
            S_EXEC: begin
                if (done) begin
                    // NOP on the done edge keeps the FSM from re-executing the word
                    instr_n = NOP_WORD;
                    adv     = 1'b1;
                end else if (timer == TW'(TIMEOUT)) begin
                    error_n = 1'b1;
                    instr_n = NOP_WORD;
                    state_n = S_HALT;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (adv) begin
            if (pc == last) begin
                state_n = S_HALT;
            end else begin
                pc_n    = pc + ADDR_W'(1);
                state_n = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            instruction <= NOP_WORD;
            timer       <= '0;
            error       <= 1'b0;
            last        <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instruction <= instr_n;
            timer       <= timer_n;
            error       <= error_n;
            last        <= last_n;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: issued words are checked by a scoreboard monitor,
// timing, halt and error behaviour by directed checks; a small model plays the control FSM.
module tb_instr_sequencer;
    localparam int INSTR_W = 10;
    localparam int ADDR_W  = 4;
    localparam logic [9:0] NOP  = 10'h380;
    localparam logic [9:0] HLT  = 10'h3C0;
    localparam logic [9:0] W_LD = 10'h008;
    localparam logic [9:0] W_AD = 10'h08A;
    localparam logic [9:0] W_XR = 10'h0CA;
    localparam logic [9:0] W_IL = 10'h140;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               load_en = 1'b0;
    logic [ADDR_W-1:0]  load_addr = '0;
    logic [INSTR_W-1:0] load_data = '0;
    logic               run = 1'b0;
    logic [ADDR_W:0]    prog_len = '0;
    logic               done = 1'b0;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  pc;
    logic               busy, halted, error;

    typedef struct { logic [9:0] instr; logic [3:0] pc; } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;
    bit fsm_en = 1'b1;
    logic [9:0] prev_instr = 10'h380;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .run(run), .prog_len(prog_len), .done(done),
        .instruction(instruction), .pc(pc), .busy(busy), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Control FSM model: done in the 2nd EXEC cycle for LOAD/MOVE, 4th for ADD/XOR
    always @(negedge clk) begin
        if (rst || !fsm_en || instruction == NOP) begin
            ecnt = 0;
            done = 1'b0;
        end else begin
            ecnt++;
            done = (ecnt == ((instruction[9:6] < 4'd2) ? 2 : 4));
        end
    end

    // Scoreboard monitor: every newly issued word is popped against the expected queue
    always @(negedge clk) begin
        if (!rst && instruction != NOP && instruction != prev_instr) begin
            if (exp_q.size() == 0) begin
                check("issue_extra", int'(instruction), int'(NOP));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("issue_word", int'(instruction), int'(e.instr));
                check("issue_pc", int'(pc), int'(e.pc));
            end
        end
        prev_instr = instruction;
    end

    task automatic expect_issue(input logic [9:0] w, input logic [3:0] p);
        exp_t e;
        e.instr = w;
        e.pc    = p;
        exp_q.push_back(e);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [9:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic do_run(input int len);
        run = 1'b1; prog_len = 5'(len);
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_issue(input string name);
        int n = 0;
        while (instruction == NOP && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(instruction != NOP), 1);
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!halted && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(halted), 1);
    endtask

    function automatic logic [9:0] t2_word(input int k);
        if (k >= 1 && k <= 4) return W_AD;
        if (k >= 6 && k <= 9) return W_XR;
        return NOP;
    endfunction

    initial begin
        int cnt;
        // reset state
        #12;
        check("rst_instr", int'(instruction), int'(NOP));
        check("rst_pc", int'(pc), 0);
        check("rst_flags", int'({busy, halted, error}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: single LOAD, held exactly 2 cycles
        do_write(4'd0, W_LD);
        expect_issue(W_LD, 4'd0);
        do_run(1);
        check("t1_fetch_nop", int'(instruction), int'(NOP));
        @(negedge clk);
        cnt = 0;
        while (instruction == W_LD && cnt < 10) begin
            cnt++;
            @(negedge clk);
        end
        check("t1_hold", cnt, 2);
        check("t1_bus_nop", int'(instruction), int'(NOP));
        check("t1_halted", int'(halted), 1);
        check("t1_pc", int'(pc), 0);
        check("t1_error", int'(error), 0);

        // 2: ADD then XOR, 4 cycles each, halted 10 cycles after the run edge
        do_write(4'd0, W_AD);
        do_write(4'd1, W_XR);
        expect_issue(W_AD, 4'd0);
        expect_issue(W_XR, 4'd1);
        do_run(2);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("t2_bus_c%0d", k), int'(instruction), int'(t2_word(k)));
            if (k == 5) check("t2_pc_step", int'(pc), 1);
            if (k == 9) check("t2_not_halted", int'(halted), 0);
        end
        check("t2_halted", int'(halted), 1);
        check("t2_pc_end", int'(pc), 1);

        // 3: NOP skipped, HALT word stops at pc=2
        do_write(4'd0, W_LD);
        do_write(4'd1, NOP);
        do_write(4'd2, HLT);
        expect_issue(W_LD, 4'd0);
        do_run(5);
        wait_halt("t3_halt_reached");
        check("t3_pc", int'(pc), 2);
        check("t3_error", int'(error), 0);
        check("t3_q_empty", exp_q.size(), 0);

        // 4: illegal opcode, then a zero-length run clears error
        do_write(4'd0, W_IL);
        do_run(1);
        @(negedge clk);
        check("t4_error", int'(error), 1);
        check("t4_halted", int'(halted), 1);
        check("t4_bus", int'(instruction), int'(NOP));
        do_run(0);
        check("t4_err_clr", int'(error), 0);
        check("t4_len0_halt", int'({busy, halted}), 1);

        // 5: watchdog with done never asserted
        fsm_en = 1'b0;
        do_write(4'd0, W_AD);
        expect_issue(W_AD, 4'd0);
        do_run(1);
        wait_issue("t5_issue");
        repeat (13) @(negedge clk);
        check("t5_no_early_err", int'(error), 0);
        check("t5_still_held", int'(instruction), int'(W_AD));
        cnt = 0;
        while (!error && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("t5_error", int'(error), 1);
        check("t5_bus_nop", int'(instruction), int'(NOP));
        check("t5_halted", int'(halted), 1);
        fsm_en = 1'b1;

        // 6: write while busy is dropped, reset mid-EXEC returns to reset values at once
        expect_issue(W_AD, 4'd0);
        do_run(1);
        wait_issue("t6_issue");
        do_write(4'd0, W_XR);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_bus", int'(instruction), int'(NOP));
        check("t6_rst_pc", int'(pc), 0);
        check("t6_rst_flags", int'({busy, halted, error}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_issue(W_AD, 4'd0);
        do_run(1);
        wait_halt("t6_readback_halt");
        check("t6_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
